// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants and pattern codes for the VGA key control path
package vga_pkg;

    localparam int NUM_PATTERNS = 4;
    localparam int NUM_COLOURS  = 8;
    localparam int PAT_W        = 2;
    localparam int COL_W        = 3;

    typedef enum logic [PAT_W-1:0] {
        PAT_SOLID = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_GRID  = 2'd2,
        PAT_BOX   = 2'd3
    } pattern_e;

endpackage

// File: rtl/vga_key_ctrl_if.sv
// rtl/vga_key_ctrl_if.sv - key inputs, frame strobe and committed selections
interface vga_key_ctrl_if;
    import vga_pkg::*;

    logic [2:0]       KEY;
    logic             frame_start;
    logic [2:0]       key_level;
    logic [2:0]       key_pulse;
    logic [PAT_W-1:0] pattern_sel;
    logic [COL_W-1:0] colour_idx;

    modport master (
        output KEY, frame_start,
        input  key_level, key_pulse, pattern_sel, colour_idx
    );

    modport slave (
        input  KEY, frame_start,
        output key_level, key_pulse, pattern_sel, colour_idx
    );

endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser, stability counter and press strobe for one key
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic CLOCK_50M,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Sync flops preset to released so a key held through reset is not seen as already pressed.
    always_ff @(posedge CLOCK_50M or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (~sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= ~level;
                pulse <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_key_ctrl.sv
// rtl/vga_key_ctrl.sv - debounced keys drive pending pattern/colour, committed at frame start
module vga_key_ctrl
    import vga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int N_PATTERNS      = NUM_PATTERNS,
    parameter int N_COLOURS       = NUM_COLOURS
) (
    input  logic          CLOCK_50M,
    input  logic          reset,
    vga_key_ctrl_if.slave bus
);

    localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(N_PATTERNS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLOURS - 1);

    logic [2:0]       level;
    logic [2:0]       pulse;
    logic [PAT_W-1:0] pend_pat;
    logic [COL_W-1:0] pend_col;
    logic [PAT_W-1:0] pattern_q;
    logic [COL_W-1:0] colour_q;

    for (genvar gi = 0; gi < 3; gi++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .CLOCK_50M(CLOCK_50M),
            .reset    (reset),
            .key_n    (bus.KEY[gi]),
            .level    (level[gi]),
            .pulse    (pulse[gi])
        );
    end

    // Commit samples the pending regs before this edge's update, so a coincident press waits a frame.
    always_ff @(posedge CLOCK_50M or negedge reset) begin
        if (!reset) begin
            pend_pat  <= '0;
            pend_col  <= '0;
            pattern_q <= '0;
            colour_q  <= '0;
        end else begin
            case ({pulse[1], pulse[0]})
                2'b01:   pend_pat <= (pend_pat == PAT_LAST) ? '0 : pend_pat + 1'b1;
                2'b10:   pend_pat <= (pend_pat == '0) ? PAT_LAST : pend_pat - 1'b1;
                default: pend_pat <= pend_pat;
            endcase
            if (pulse[2]) begin
                pend_col <= (pend_col == COL_LAST) ? '0 : pend_col + 1'b1;
            end
            if (bus.frame_start) begin
                pattern_q <= pend_pat;
                colour_q  <= pend_col;
            end
        end
    end

    assign bus.key_level   = level;
    assign bus.key_pulse   = pulse;
    assign bus.pattern_sel = pattern_q;
    assign bus.colour_idx  = colour_q;

endmodule

// File: tb/tb_vga_key_ctrl.sv
// tb/tb_vga_key_ctrl.sv - scoreboard bench for vga_key_ctrl with an 8-cycle debounce window
module tb_vga_key_ctrl;

    localparam int DB = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [2:0] exp_pulse[$];
    logic [4:0] exp_commit[$];
    logic [1:0] m_pat;
    logic [2:0] m_col;

    vga_key_ctrl_if bus();

    vga_key_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .N_PATTERNS     (4),
        .N_COLOURS      (8)
    ) dut (
        .CLOCK_50M(clk),
        .reset    (rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && bus.key_pulse != 3'b000) begin
            checks++;
            if (exp_pulse.size() == 0) begin
                errors++;
                $display("FAIL spurious_pulse got %b expected none", bus.key_pulse);
            end else begin
                logic [2:0] e;
                e = exp_pulse.pop_front();
                if (bus.key_pulse !== e) begin
                    errors++;
                    $display("FAIL pulse got %b expected %b", bus.key_pulse, e);
                end
            end
        end
    end

    function automatic logic [1:0] pat_inc(input logic [1:0] p);
        return (p == 2'd3) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [1:0] pat_dec(input logic [1:0] p);
        return (p == 2'd0) ? 2'd3 : p - 2'd1;
    endfunction

    function automatic logic [2:0] col_inc(input logic [2:0] c);
        return (c == 3'd7) ? 3'd0 : c + 3'd1;
    endfunction

    task automatic check_commit(input string name);
        logic [4:0] e;
        checks++;
        if (exp_commit.size() == 0) begin
            errors++;
            $display("FAIL %s commit queue empty", name);
        end else begin
            e = exp_commit.pop_front();
            if ({bus.pattern_sel, bus.colour_idx} !== e)begin
                errors++;
                $display("FAIL %s pat/col got %0d/%0d expected %0d/%0d", name,
                         bus.pattern_sel, bus.colour_idx, e[4:3], e[2:0]);
            end
        end
    endtask

    task automatic frame(input string name);
        @(posedge clk); #1 bus.frame_start = 1'b1;
        exp_commit.push_back({m_pat, m_col});
        @(posedge clk); #1 bus.frame_start = 1'b0;
        check_commit(name);
    endtask

    task automatic press(input logic [2:0] mask);
        exp_pulse.push_back(mask);
        @(posedge clk); #1 bus.KEY = ~mask;
        repeat (12) @(posedge clk);
        #1 bus.KEY = 3'b111;
        repeat (12) @(posedge clk);
    endtask

    task automatic wait_level(input int idx, output int n);
        n = 31;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (bus.key_level[idx]) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic quiet;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (bus.key_pulse !== 3'b000 || bus.key_level !== 3'b000) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL reset_quiet got activity expected none"); end
        checks++;
        if (bus.pattern_sel !== 2'd0) begin
            errors++; $display("FAIL reset_pat got %0d expected 0", bus.pattern_sel);
        end
        checks++;
        if (bus.colour_idx !== 3'd0) begin
            errors++; $display("FAIL reset_col got %0d expected 0", bus.colour_idx);
        end
    endtask

    task automatic test_latency();
        int n;
        exp_pulse.push_back(3'b001);
        m_pat = pat_inc(m_pat);
        @(posedge clk); #1 bus.KEY[0] = 1'b0;
        wait_level(0, n);
        checks++;
        if (n !== DB + 2) begin
            errors++; $display("FAIL latency got %0d expected %0d", n, DB + 2);
        end
        repeat (20 - n) @(posedge clk);
        #1 bus.KEY[0] = 1'b1;
        repeat (14) @(posedge clk);
        frame("latency_commit");
    endtask

    task automatic test_bounce();
        logic stayed_low;
        stayed_low = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) bus.KEY[0] = ~bus.KEY[0];
            @(posedge clk); #1;
            if (bus.key_level[0] !== 1'b0) stayed_low = 1'b0;
        end
        bus.KEY[0] = 1'b1;
        repeat (15) @(posedge clk); #1;
        if (bus.key_level[0] !== 1'b0) stayed_low = 1'b0;
        checks++;
        if (!stayed_low) begin errors++; $display("FAIL bounce_level got 1 expected 0"); end
        frame("bounce_commit");
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 4; k++) begin
            press(3'b010);
            m_pat = pat_dec(m_pat);
            frame("wrap_pat");
        end
        for (int k = 0; k < 9; k++) begin
            press(3'b100);
            m_col = col_inc(m_col);
        end
        frame("wrap_col");
    endtask

    task automatic test_back_to_back();
        press(3'b011);
        frame("simul_pat");
        exp_pulse.push_back(3'b100);
        @(posedge clk); #1 bus.KEY = 3'b011;
        repeat (DB + 2) @(posedge clk);
        #1;
        checks++;
        if (bus.key_pulse[2] !== 1'b1) begin
            errors++; $display("FAIL coincident_pulse got %b expected 1", bus.key_pulse[2]);
        end
        bus.frame_start = 1'b1;
        exp_commit.push_back({m_pat, m_col});
        m_col = col_inc(m_col);
        @(posedge clk); #1 bus.frame_start = 1'b0;
        check_commit("coincident_old");
        repeat (2) @(posedge clk);
        #1 bus.KEY = 3'b111;
        repeat (12) @(posedge clk);
        frame("coincident_new");
    endtask

    task automatic test_reset_mid();
        int n;
        @(posedge clk); #1 bus.KEY = 3'b110;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.key_level, bus.key_pulse, bus.pattern_sel, bus.colour_idx} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs got %b expected 0",
                     {bus.key_level, bus.key_pulse, bus.pattern_sel, bus.colour_idx});
        end
        m_pat = 2'd0;
        m_col = 3'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_pulse.push_back(3'b001);
        m_pat = pat_inc(m_pat);
        wait_level(0, n);
        checks++;
        if (n !== DB + 2) begin
            errors++; $display("FAIL reset_mid_latency got %0d expected %0d", n, DB + 2);
        end
        #1 bus.KEY = 3'b111;
        repeat (14) @(posedge clk);
        frame("reset_mid_commit");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_pat = 2'd0;
        m_col = 3'd0;
        rst_n = 1'b0;
        bus.KEY = 3'b111;
        bus.frame_start = 1'b0;
        test_reset();
        test_latency();
        test_bounce();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(posedge clk);
        checks++;
        if (exp_pulse.size() != 0) begin
            errors++; $display("FAIL missing_pulses got %0d left expected 0", exp_pulse.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
